// File: rtl/unidade_controle_if.sv
// Neander control unit <-> datapath/timer bundle.
// master: the control unit (consumes phase/opcode/flags, drives strobes).
// slave : the datapath + timer side.
//
// Handshake: there is no valid/ready pair. The one-hot phase vector t
// qualifies every strobe. A strobe is meaningful only in the cycle whose
// phase is active, and it takes effect at the next ck edge. gotoT0 is the
// control unit's request that the timer restart at T0 on that same next
// edge. A non-one-hot t is never a valid phase.
interface unidade_controle_if;
  logic [2:0] t;
  logic [3:0] opcode;
  logic       flag_n;
  logic       flag_z;
  logic       gotoT0;
  logic       cargaREM;
  logic       selREM;
  logic       incPC;
  logic       cargaPC;
  logic       read;
  logic       write;
  logic       cargaRDM;
  logic       selRDM;
  logic       cargaRI;
  logic       cargaAC;
  logic       cargaNZ;
  logic [2:0] selUAL;
  logic [1:0] ciclo;
  logic       halted;
  logic       illegal;

  modport master (
    input  t, opcode, flag_n, flag_z,
    output gotoT0, cargaREM, selREM, incPC, cargaPC, read, write,
           cargaRDM, selRDM, cargaRI, cargaAC, cargaNZ, selUAL,
           ciclo, halted, illegal
  );

  modport slave (
    output t, opcode, flag_n, flag_z,
    input  gotoT0, cargaREM, selREM, incPC, cargaPC, read, write,
           cargaRDM, selRDM, cargaRI, cargaAC, cargaNZ, selUAL,
           ciclo, halted, illegal
  );
endinterface

// File: rtl/unidade_controle.sv
// Neander control unit: cycle FSM (BUSCA/EXEC_A/EXEC_B/HALT) stretched
// over the three-phase timer, with all datapath strobes decoded
// combinationally from ciclo, t, opcode and the N/Z flags.
// Optional feature macro: UC_ILLEGAL_HALT_EN (undefined opcodes halt and
// raise illegal; without it they behave as NOP and illegal is tied 0).
module unidade_controle (
  input  logic               ck,
  input  logic               nreset,
  unidade_controle_if.master bus
);

  typedef enum logic [1:0] {
    BUSCA  = 2'b00,
    EXEC_A = 2'b01,
    EXEC_B = 2'b10,
    HALT   = 2'b11
  } ciclo_t;

  ciclo_t r_ciclo;
  ciclo_t w_next;

  logic w_t0, w_t1, w_t2, w_t_ok;
  logic w_mem, w_sta, w_jump, w_taken, w_not, w_undef;
  logic [2:0] w_alu;

  // Phase and opcode class decode
  always_comb begin
    w_t0    = (bus.t == 3'b001);
    w_t1    = (bus.t == 3'b010);
    w_t2    = (bus.t == 3'b100);
    w_t_ok  = w_t0 | w_t1 | w_t2;
    w_mem   = (bus.opcode >= 4'h1) && (bus.opcode <= 4'h5);
    w_sta   = (bus.opcode == 4'h1);
    w_jump  = (bus.opcode == 4'h8) || (bus.opcode == 4'h9) || (bus.opcode == 4'hA);
    w_taken = (bus.opcode == 4'h8) || ((bus.opcode == 4'h9) && bus.flag_n) ||
              ((bus.opcode == 4'hA) && bus.flag_z);
    w_not   = (bus.opcode == 4'h6);
    w_undef = (bus.opcode == 4'h7) || ((bus.opcode >= 4'hB) && (bus.opcode <= 4'hE));
    case (bus.opcode)
      4'h2:    w_alu = 3'b100;
      4'h3:    w_alu = 3'b000;
      4'h4:    w_alu = 3'b010;
      4'h5:    w_alu = 3'b001;
      default: w_alu = 3'b000;
    endcase
  end

  // Cycle register; the only state in the block
  always_ff @(posedge ck or negedge nreset) begin
    if (!nreset) r_ciclo <= BUSCA;
    else         r_ciclo <= w_next;
  end

  // Next-state and strobe decode; reset and invalid phases force a quiet
  // cycle with gotoT0 so an unreset timer is pulled back to T0
  always_comb begin
    w_next       = r_ciclo;
    bus.gotoT0   = 1'b0;
    bus.cargaREM = 1'b0;
    bus.selREM   = 1'b0;
    bus.incPC    = 1'b0;
    bus.cargaPC  = 1'b0;
    bus.read     = 1'b0;
    bus.write    = 1'b0;
    bus.cargaRDM = 1'b0;
    bus.selRDM   = 1'b0;
    bus.cargaRI  = 1'b0;
    bus.cargaAC  = 1'b0;
    bus.cargaNZ  = 1'b0;
    bus.selUAL   = 3'b000;
    if (!nreset || !w_t_ok) begin
      bus.gotoT0 = 1'b1;
    end else begin
      case (r_ciclo)
        BUSCA: begin
          if (w_t0) bus.cargaREM = 1'b1;
          if (w_t1) begin
            bus.read = 1'b1; bus.cargaRDM = 1'b1; bus.incPC = 1'b1;
          end
          if (w_t2) begin
            bus.cargaRI = 1'b1;
            // opcode is already on the RI input path at this edge
            if (bus.opcode == 4'hF) w_next = HALT;
            else if (w_mem || w_jump || w_not) w_next = EXEC_A;
`ifdef UC_ILLEGAL_HALT_EN
            else if (w_undef) w_next = HALT;
`endif
            else w_next = BUSCA;
          end
        end
        EXEC_A: begin
          if (w_mem) begin
            if (w_t0) bus.cargaREM = 1'b1;
            if (w_t1) begin
              bus.read = 1'b1; bus.cargaRDM = 1'b1; bus.incPC = 1'b1;
            end
            if (w_t2) begin
              bus.cargaREM = 1'b1; bus.selREM = 1'b1; w_next = EXEC_B;
            end
          end else if (w_jump) begin
            // flags only matter at T0; reaching T1/T2 means the branch is taken
            if (w_t0 && w_taken) bus.cargaREM = 1'b1;
            if (w_t0 && !w_taken) begin
              bus.incPC = 1'b1; bus.gotoT0 = 1'b1; w_next = BUSCA;
            end
            if (w_t1) begin
              bus.read = 1'b1; bus.cargaRDM = 1'b1;
            end
            if (w_t2) begin
              bus.cargaPC = 1'b1; w_next = BUSCA;
            end
          end else if (w_not && w_t0) begin
            bus.selUAL = 3'b011; bus.cargaAC = 1'b1; bus.cargaNZ = 1'b1;
            bus.gotoT0 = 1'b1; w_next = BUSCA;
          end else begin
            bus.gotoT0 = 1'b1; w_next = BUSCA;
          end
        end
        EXEC_B: begin
          if (w_mem && w_t0) begin
            bus.cargaRDM = 1'b1;
            if (w_sta) bus.selRDM = 1'b1;
            else       bus.read   = 1'b1;
          end else if (w_mem && w_t1) begin
            if (w_sta) bus.write = 1'b1;
            else begin
              bus.selUAL = w_alu; bus.cargaAC = 1'b1; bus.cargaNZ = 1'b1;
            end
            bus.gotoT0 = 1'b1; w_next = BUSCA;
          end else begin
            bus.gotoT0 = 1'b1; w_next = BUSCA;
          end
        end
        default: bus.gotoT0 = 1'b1;
      endcase
    end
  end

  assign bus.ciclo  = r_ciclo;
  assign bus.halted = (r_ciclo == HALT);
`ifdef UC_ILLEGAL_HALT_EN
  // RI is never loaded while halted, so the opcode still names the cause
  assign bus.illegal = (r_ciclo == HALT) && w_undef;
`else
  assign bus.illegal = 1'b0;
`endif

endmodule

// File: tb/tb_unidade_controle.sv
// Bench for unidade_controle. Honours UC_ILLEGAL_HALT_EN like the design.
module tb_unidade_controle;
  localparam int W = 19;
  localparam logic [W-1:0] S_GOTO = W'(1) << 0;
  localparam logic [W-1:0] S_REM  = W'(1) << 1;
  localparam logic [W-1:0] S_SREM = W'(1) << 2;
  localparam logic [W-1:0] S_INC  = W'(1) << 3;
  localparam logic [W-1:0] S_PC   = W'(1) << 4;
  localparam logic [W-1:0] S_RD   = W'(1) << 5;
  localparam logic [W-1:0] S_WR   = W'(1) << 6;
  localparam logic [W-1:0] S_RDM  = W'(1) << 7;
  localparam logic [W-1:0] S_SRDM = W'(1) << 8;
  localparam logic [W-1:0] S_RI   = W'(1) << 9;
  localparam logic [W-1:0] S_AC   = W'(1) << 10;
  localparam logic [W-1:0] S_NZ   = W'(1) << 11;
  localparam logic [W-1:0] S_HALT = W'(1) << 15;
  localparam logic [W-1:0] S_ILL  = W'(1) << 16;

  // clock / reset
  logic ck = 1'b0;
  logic nreset = 1'b0;
  always #5 ck = ~ck;

  unidade_controle_if bus ();
  unidade_controle dut (.ck(ck), .nreset(nreset), .bus(bus));

  // scoreboard state
  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           n_checks = 0;
  int           n_errors = 0;

  // reference program for the current instruction
  logic [W-1:0] prog_q[$];
  bit           prog_halt;
  bit           prog_ill;
  bit           inj;
  logic [2:0]   bad_t[5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

  function automatic logic [W-1:0] cyc(input int c);
    return W'(c) << 17;
  endfunction

  function automatic logic [W-1:0] alu(input int s);
    return W'(s) << 12;
  endfunction

  function automatic bit is_undef(input logic [3:0] op);
    return (op == 4'h7) || (op >= 4'hB && op <= 4'hE);
  endfunction

  // Per-instruction list of expected cycles, from the instruction table
  task automatic build(input logic [3:0] op, input logic n, input logic z);
    bit taken;
    prog_q.delete();
    prog_halt = 1'b0;
    prog_ill  = 1'b0;
    prog_q.push_back(cyc(0) | S_REM);
    prog_q.push_back(cyc(0) | S_RD | S_RDM | S_INC);
    prog_q.push_back(cyc(0) | S_RI);
    case (op)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
        prog_q.push_back(cyc(1) | S_REM);
        prog_q.push_back(cyc(1) | S_RD | S_RDM | S_INC);
        prog_q.push_back(cyc(1) | S_REM | S_SREM);
        if (op == 4'h1) begin
          prog_q.push_back(cyc(2) | S_RDM | S_SRDM);
          prog_q.push_back(cyc(2) | S_WR | S_GOTO);
        end else begin
          prog_q.push_back(cyc(2) | S_RD | S_RDM);
          prog_q.push_back(cyc(2) | S_AC | S_NZ | S_GOTO |
                           alu(op == 4'h2 ? 4 : op == 4'h3 ? 0 : op == 4'h4 ? 2 : 1));
        end
      end
      4'h6: prog_q.push_back(cyc(1) | alu(3) | S_AC | S_NZ | S_GOTO);
      4'h8, 4'h9, 4'hA: begin
        taken = (op == 4'h8) || (op == 4'h9 && n) || (op == 4'hA && z);
        if (taken) begin
          prog_q.push_back(cyc(1) | S_REM);
          prog_q.push_back(cyc(1) | S_RD | S_RDM);
          prog_q.push_back(cyc(1) | S_PC);
        end else begin
          prog_q.push_back(cyc(1) | S_INC | S_GOTO);
        end
      end
      4'hF: prog_halt = 1'b1;
      default: begin
`ifdef UC_ILLEGAL_HALT_EN
        if (is_undef(op)) begin
          prog_halt = 1'b1;
          prog_ill  = 1'b1;
        end
`endif
      end
    endcase
  endtask

  // driver: apply inputs just after the edge, post the expected response
  task automatic drive(input logic r, input logic [2:0] tt, input logic [3:0] op,
                       input logic n, input logic z, input logic [W-1:0] e,
                       input string tag);
    @(posedge ck);
    #1;
    nreset     = r;
    bus.t      = tt;
    bus.opcode = op;
    bus.flag_n = n;
    bus.flag_z = z;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic reset_pulse(input int cycles);
    for (int i = 0; i < cycles; i++)
      drive(1'b0, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), S_GOTO, "reset");
  endtask

  task automatic run_instr(input logic [3:0] op, input logic n, input logic z,
                           input int abort_at);
    logic fn, fz;
    build(op, n, z);
    for (int k = 0; k < prog_q.size(); k++) begin
      if (k == abort_at) begin
        reset_pulse(2);
        return;
      end
      if (inj && $urandom_range(0, 7) == 0)
        drive(1'b1, bad_t[$urandom_range(0, 4)], op, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), cyc(int'(prog_q[k][18:17])) | S_GOTO,
              $sformatf("bad_t_op%0h_k%0d", op, k));
      fn = (k == 3) ? n : 1'($urandom_range(0, 1));
      fz = (k == 3) ? z : 1'($urandom_range(0, 1));
      drive(1'b1, 3'(1 << (k % 3)), op, fn, fz, prog_q[k],
            $sformatf("op%0h_n%0d_z%0d_k%0d", op, n, z, k));
    end
    if (prog_halt) begin
      for (int i = 0; i < 20; i++)
        drive(1'b1, 3'b001, op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              cyc(3) | S_HALT | S_GOTO | (prog_ill ? S_ILL : '0),
              $sformatf("halt_op%0h_%0d", op, i));
      reset_pulse(2);
    end
  endtask

  // monitor: one output vector per cycle, compared against the queue head
  logic [W-1:0] mon_e, mon_a;
  string        mon_tag;
  always @(negedge ck) begin
    if (exp_q.size() != 0) begin
      mon_e   = exp_q.pop_front();
      mon_tag = tag_q.pop_front();
      mon_a   = {bus.ciclo, bus.illegal, bus.halted, bus.selUAL, bus.cargaNZ,
                 bus.cargaAC, bus.cargaRI, bus.selRDM, bus.cargaRDM, bus.write,
                 bus.read, bus.cargaPC, bus.incPC, bus.selREM, bus.cargaREM,
                 bus.gotoT0};
      n_checks++;
      if (mon_a !== mon_e) begin
        n_errors++;
        $display("FAIL %s: got %05h expected %05h", mon_tag, mon_a, mon_e);
      end
    end
  end

  // stimulus
  initial begin
    bus.t      = 3'b000;
    bus.opcode = 4'h0;
    bus.flag_n = 1'b0;
    bus.flag_z = 1'b0;
    inj        = 1'b0;
    drive(1'b0, 3'b000, 4'h2, 1'b0, 1'b0, S_GOTO, "reset_t000");
    drive(1'b0, 3'b001, 4'h1, 1'b0, 1'b0, S_GOTO, "reset_t001");
    run_instr(4'h2, 1'b0, 1'b0, -1);
    run_instr(4'h1, 1'b0, 1'b0, -1);
    run_instr(4'h9, 1'b0, 1'b0, -1);
    run_instr(4'h9, 1'b1, 1'b0, -1);
    run_instr(4'hA, 1'b0, 1'b1, -1);
    run_instr(4'hA, 1'b1, 1'b0, -1);
    run_instr(4'h8, 1'b0, 1'b0, -1);
    run_instr(4'h6, 1'b0, 1'b0, -1);
    run_instr(4'h0, 1'b0, 1'b0, -1);
    run_instr(4'h3, 1'b0, 1'b0, -1);
    run_instr(4'h4, 1'b0, 1'b0, -1);
    run_instr(4'h5, 1'b0, 1'b0, -1);
    run_instr(4'hC, 1'b0, 1'b0, -1);
    run_instr(4'h1, 1'b0, 1'b0, 7);
    run_instr(4'h2, 1'b0, 1'b0, 5);
    run_instr(4'hF, 1'b0, 1'b0, -1);
    inj = 1'b1;
    for (int i = 0; i < 80; i++)
      run_instr(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), -1);
    repeat (3) @(posedge ck);
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // run-time bound
  initial begin
    #2000000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
